display_scan_ctrl: RTL and testbench

Time-multiplexing scan controller that shares one BCD-to-segment decoder among several physical digits. It holds a frame of BCD codes, presents one code at a time on `bcd_out` to the shared decoder, and drives a one-hot digit enable with a dark guard interval between digits to prevent ghosting. New display contents are double-buffered and committed only at frame boundaries, so a displayed frame never mixes old and new digits.

---
 rtl/display_scan_ctrl.sv | 79 +++++++
 tb/tb_display_scan_ctrl.sv | 106 ++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: multiplexes a double-buffered BCD frame onto one shared decoder with guarded one-hot digit enables.
module display_scan_ctrl #(
  parameter int DIGITS       = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     blank_in,
  output logic [3:0]            bcd_out,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  pending,
  output logic                  frame_done
);
  localparam int MX = PRESCALE > BLANK_CYCLES ? PRESCALE : BLANK_CYCLES;
  localparam int CW = $clog2(MX) > 0 ? $clog2(MX) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam logic ST_BLANK = 1'b0;
  localparam logic ST_SHOW  = 1'b1;
  localparam logic ST_RST   = BLANK_CYCLES == 0 ? ST_SHOW : ST_BLANK;
  logic                state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] act_dig_q, act_dig_d, sh_dig_q, sh_dig_d;
  logic [DIGITS-1:0]   act_blk_q, act_blk_d, sh_blk_q, sh_blk_d;
  logic                pending_q, pending_d;
  logic [3:0]          bcd_q, bcd_d;
  logic [DIGITS-1:0]   en_q, en_d;
  logic                fd_q;
  logic                last, commit;
  always_comb begin
    last      = cnt_q == (state_q == ST_SHOW ? CW'(PRESCALE - 1) : CW'(BLANK_CYCLES - 1));
    commit    = state_q == ST_SHOW && last && idx_q == IW'(DIGITS - 1);
    state_d   = last ? (state_q == ST_BLANK ? ST_SHOW : ST_RST) : state_q;
    cnt_d     = last ? '0 : cnt_q + 1'b1;
    idx_d     = (state_q == ST_SHOW && last) ? (idx_q == IW'(DIGITS - 1) ? '0 : idx_q + 1'b1) : idx_q;
    // A load landing on the commit edge bypasses the shadow entirely.
    act_dig_d = commit && load ? digits_in : commit && pending_q ? sh_dig_q : act_dig_q;
    act_blk_d = commit && load ? blank_in  : commit && pending_q ? sh_blk_q : act_blk_q;
    sh_dig_d  = load && !commit ? digits_in : sh_dig_q;
    sh_blk_d  = load && !commit ? blank_in  : sh_blk_q;
    pending_d = commit ? 1'b0 : load ? 1'b1 : pending_q;
    bcd_d     = act_dig_d[{idx_d, 2'b00} +: 4];
    en_d      = (state_d == ST_SHOW && !act_blk_d[idx_d]) ? DIGITS'(1) << idx_d : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RST;
      cnt_q     <= '0;
      idx_q     <= '0;
      act_dig_q <= '0;
      act_blk_q <= '0;
      sh_dig_q  <= '0;
      sh_blk_q  <= '0;
      pending_q <= 1'b0;
      bcd_q     <= '0;
      en_q      <= '0;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      act_dig_q <= act_dig_d;
      act_blk_q <= act_blk_d;
      sh_dig_q  <= sh_dig_d;
      sh_blk_q  <= sh_blk_d;
      pending_q <= pending_d;
      bcd_q     <= bcd_d;
      en_q      <= en_d;
      fd_q      <= commit;
    end
  end
  assign bcd_out    = bcd_q;
  assign digit_en   = en_q;
  assign pending    = pending_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed scenarios checked every cycle against a frame-position model plus literal pins.
module tb_display_scan_ctrl;
  localparam int D = 4, P = 4, B = 1, SLOT = P + B, FRAME = D * SLOT;
  logic        clk = 0, reset = 1, load = 0;
  logic [15:0] digits_in = '0;
  logic [3:0]  blank_in = '0;
  logic [3:0]  bcd_out, digit_en;
  logic        pending, frame_done;
  int vecs = 0, errs = 0, cyc = 0;
  display_scan_ctrl #(.DIGITS(D), .PRESCALE(P), .BLANK_CYCLES(B)) dut (
    .clk(clk), .reset(reset), .load(load), .digits_in(digits_in), .blank_in(blank_in),
    .bcd_out(bcd_out), .digit_en(digit_en), .pending(pending), .frame_done(frame_done));
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // Model: position within the frame decides the slot; act/shadow follow the commit rules.
  int          t = 0;
  logic        armed = 0, m_pend = 0;
  logic [15:0] m_act = '0, m_sh = '0;
  logic [3:0]  m_ablk = '0, m_sblk = '0;
  always @(posedge clk) begin
    if (reset) begin
      t <= 0; armed <= 1; m_pend <= 0;
      m_act <= '0; m_sh <= '0; m_ablk <= '0; m_sblk <= '0;
    end else begin
      t <= t + 1;
      if (t % FRAME == FRAME - 1) begin
        if (load) begin m_act <= digits_in; m_ablk <= blank_in; end
        else if (m_pend) begin m_act <= m_sh; m_ablk <= m_sblk; end
        m_pend <= 0;
      end else if (load) begin
        m_sh <= digits_in; m_sblk <= blank_in; m_pend <= 1;
      end
    end
  end
  always @(negedge clk) begin
    if (armed) begin
      int p, d, s;
      logic [15:0] a;
      p = t % FRAME; d = p / SLOT; s = p % SLOT; a = m_act;
      chk("digit_en", int'(digit_en), (s >= B && !m_ablk[d]) ? (1 << d) : 0);
      chk("bcd_out", int'(bcd_out), int'((a >> (4 * d)) & 16'hF));
      chk("pending", int'(pending), int'(m_pend));
      chk("frame_done", int'(frame_done), (t != 0 && p == 0) ? 1 : 0);
    end
  end
  task automatic step();
    @(posedge clk); #1; cyc++;
  endtask
  task automatic wait_to(input int c);
    while (cyc < c) step();
  endtask
  task automatic do_load(input int c, input logic [15:0] dg, input logic [3:0] bk);
    wait_to(c);
    load = 1; digits_in = dg; blank_in = bk;
    step();
    load = 0;
  endtask
  task automatic do_reset();
    reset = 1;
    step();
    reset = 0; cyc = 0;
    chk("rst_en", int'(digit_en), 0);
    chk("rst_bcd", int'(bcd_out), 0);
    chk("rst_pend", int'(pending), 0);
    chk("rst_fd", int'(frame_done), 0);
  endtask
  initial begin
    @(posedge clk); #1;
    do_reset();
    wait_to(6);  chk("idle_en_d1", int'(digit_en), 4'b0010);
    wait_to(20); chk("idle_fd20", int'(frame_done), 1);
    wait_to(21); chk("idle_fd21", int'(frame_done), 0);
    wait_to(40); chk("idle_fd40", int'(frame_done), 1);
    do_reset();
    do_load(3, 16'h4321, 4'b0000);
    chk("pend_c4", int'(pending), 1);
    wait_to(19); chk("old_frame_bcd", int'(bcd_out), 0);
    wait_to(20); chk("commit_pend", int'(pending), 0);
    wait_to(21); chk("new_bcd_d0", int'(bcd_out), 1); chk("new_en_d0", int'(digit_en), 4'b0001);
    do_load(25, 16'h1111, 4'b0000);
    do_load(30, 16'h9876, 4'b0000);
    wait_to(36); chk("keep_4321_d3", int'(bcd_out), 4); chk("en_d3", int'(digit_en), 4'b1000);
    wait_to(41); chk("last_wins_d0", int'(bcd_out), 6);
    do_load(59, 16'h5555, 4'b0000);
    chk("commit_load_pend", int'(pending), 0);
    wait_to(60); chk("commit_load_bcd", int'(bcd_out), 5);
    do_load(65, 16'h4321, 4'b1010);
    wait_to(86); chk("blk_d1_en", int'(digit_en), 0); chk("blk_d1_bcd", int'(bcd_out), 2);
    wait_to(91); chk("unblk_d2_en", int'(digit_en), 4'b0100);
    wait_to(96); chk("blk_d3_bcd", int'(bcd_out), 4);
    do_load(100, 16'h7777, 4'b0000);
    wait_to(112); chk("pre_rst_pend", int'(pending), 1); chk("pre_rst_en", int'(digit_en), 4'b0100);
    do_reset();
    wait_to(1); chk("restart_en", int'(digit_en), 4'b0001);
    wait_to(21); chk("cleared_bcd", int'(bcd_out), 0);
    wait_to(25);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
